switch_debounce_sync: RTL and testbench



---
 rtl/switch_debounce_sync.sv | 117 +++++++++++
 tb/tb_switch_debounce_sync.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_sync.sv
// Switch conditioner: 2-flop synchronizer followed by a stability-qualifying debounce FSM.
// Produces a registered clean level plus one-cycle rise/fall strobes.
module switch_debounce_sync #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic clr_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);
    // state     | meaning
    // IDLE_LOW  | dout=0, synchronized input agrees
    // CHK_HIGH  | s2=1 seen, counting toward accepting 1
    // IDLE_HIGH | dout=1, synchronized input agrees
    // CHK_LOW   | s2=0 seen, counting toward accepting 0
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        CHK_HIGH  = 2'd1,
        IDLE_HIGH = 2'd2,
        CHK_LOW   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                IDLE_LOW: begin
                    if (r_s2) begin
                        r_state <= CHK_HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CHK_HIGH: begin
                    if (!r_s2) begin
                        r_state <= IDLE_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE_HIGH;
                        r_cnt   <= '0;
                        r_dout  <= 1'b1;
                        r_rise  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!r_s2) begin
                        r_state <= CHK_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CHK_LOW: begin
                    if (r_s2) begin
                        r_state <= IDLE_HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE_LOW;
                        r_cnt   <= '0;
                        r_dout  <= 1'b0;
                        r_fall  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE_LOW;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = r_busy;
endmodule

// File: tb/tb_switch_debounce_sync.sv
// Bench for switch_debounce_sync: vector table, hand-written reset/glitch sequences,
// and random din compared against a run-length reference model.
module tb_switch_debounce_sync;
    localparam int STABLE = 4;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    logic din   = 1'b0;
    logic dout, rise, fall, busy;

    int n_total  = 0;
    int n_passed = 0;

    switch_debounce_sync #(.STABLE_CYCLES(STABLE), .CNT_W(16)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .din   (din),
        .dout  (dout),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    always #50 clk = ~clk;

    // Reference: the observed level is din as sampled two edges earlier; the output
    // adopts a new level once that level has been observed STABLE+1 times in a row.
    logic pipe [2] = '{1'b0, 1'b0};
    logic m_val  = 1'b0;
    int   m_run  = STABLE + 1;
    logic m_dout = 1'b0;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;
    logic m_busy = 1'b0;

    always @(posedge clk or negedge clr_n) begin
        logic obs;
        if (!clr_n) begin
            pipe[0] = 1'b0; pipe[1] = 1'b0;
            m_val = 1'b0; m_run = STABLE + 1;
            m_dout = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
        end else begin
            obs = pipe[0];
            pipe[0] = pipe[1];
            pipe[1] = din;
            if (obs == m_val) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_val = obs;
                m_run = 1;
            end
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (obs != m_dout && m_run == STABLE + 1) begin
                m_dout = obs;
                m_rise = obs;
                m_fall = ~obs;
            end
            m_busy = (obs != m_dout);
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got {dout,rise,fall,busy}=%b, want %b at %0t", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_passed++;
        else $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    endtask

    // Edge index (from first edge after release) at which rise is first seen; -1 if none.
    task automatic wait_rise(output int edge_idx, output int n_rise);
        edge_idx = -1;
        n_rise = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (rise) begin
                n_rise++;
                if (edge_idx < 0) edge_idx = e;
            end
        end
    endtask

    typedef struct {
        logic       din;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int idx, nr, hold;

        // clean rise, clean fall, bounce during CHK_HIGH, abort of CHK_LOW at cnt==STABLE-1
        tbl.push_back('{1'b1, 4'b0000}); tbl.push_back('{1'b1, 4'b0000});
        tbl.push_back('{1'b1, 4'b0001}); tbl.push_back('{1'b1, 4'b0001});
        tbl.push_back('{1'b1, 4'b0001}); tbl.push_back('{1'b1, 4'b0001});
        tbl.push_back('{1'b1, 4'b1100}); tbl.push_back('{1'b1, 4'b1000});
        tbl.push_back('{1'b0, 4'b1000}); tbl.push_back('{1'b0, 4'b1000});
        tbl.push_back('{1'b0, 4'b1001}); tbl.push_back('{1'b0, 4'b1001});
        tbl.push_back('{1'b0, 4'b1001}); tbl.push_back('{1'b0, 4'b1001});
        tbl.push_back('{1'b0, 4'b0010}); tbl.push_back('{1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000}); tbl.push_back('{1'b1, 4'b0000});
        tbl.push_back('{1'b1, 4'b0001}); tbl.push_back('{1'b0, 4'b0001});
        tbl.push_back('{1'b1, 4'b0001}); tbl.push_back('{1'b1, 4'b0000});
        tbl.push_back('{1'b1, 4'b0001}); tbl.push_back('{1'b1, 4'b0001});
        tbl.push_back('{1'b1, 4'b0001}); tbl.push_back('{1'b1, 4'b0001});
        tbl.push_back('{1'b1, 4'b1100}); tbl.push_back('{1'b1, 4'b1000});
        tbl.push_back('{1'b0, 4'b1000}); tbl.push_back('{1'b0, 4'b1000});
        tbl.push_back('{1'b0, 4'b1001}); tbl.push_back('{1'b0, 4'b1001});
        tbl.push_back('{1'b1, 4'b1001}); tbl.push_back('{1'b1, 4'b1001});
        tbl.push_back('{1'b1, 4'b1000}); tbl.push_back('{1'b1, 4'b1000});

        // reset held with din=1, then release
        din = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("reset_hold", {dout, rise, fall, busy}, 4'b0000);
        end
        @(negedge clk); clr_n = 1'b1;
        wait_rise(idx, nr);
        check_int("reset_release_rise_edge", idx, 6);
        check_int("reset_release_rise_width", nr, 1);
        check("reset_release_level", {dout, rise, fall, busy}, 4'b1000);

        // async reset while dout=1 must clear before any edge
        @(negedge clk); #10 clr_n = 1'b0; #1;
        check("async_reset_dout", {dout, rise, fall, busy}, 4'b0000);

        // table
        din = 1'b0;
        @(negedge clk); clr_n = 1'b1;
        foreach (tbl[i]) begin
            @(negedge clk); din = tbl[i].din;
            @(posedge clk); #1;
            check($sformatf("table_row%0d", i), {dout, rise, fall, busy}, tbl[i].exp);
        end

        // reset mid-CHK_HIGH at cnt=2
        @(negedge clk); clr_n = 1'b0; din = 1'b1;
        @(negedge clk); clr_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("mid_chk_busy", {dout, rise, fall, busy}, 4'b0001);
        #10 clr_n = 1'b0; #1;
        check("mid_chk_async_clear", {dout, rise, fall, busy}, 4'b0000);
        @(negedge clk); clr_n = 1'b1;
        wait_rise(idx, nr);
        check_int("mid_chk_rerise_edge", idx, 6);
        check_int("mid_chk_rerise_width", nr, 1);

        // glitch between edges is never captured
        @(negedge clk); din = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("pre_glitch_low", {dout, rise, fall, busy}, 4'b0000);
        @(posedge clk); #20 din = 1'b1; #30 din = 1'b0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            check($sformatf("glitch_edge%0d", e), {dout, rise, fall, busy}, 4'b0000);
        end

        // random bouncing input with occasional resets vs reference model
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check("random_vs_model", {dout, rise, fall, busy}, {m_dout, m_rise, m_fall, m_busy});
            if (!clr_n) clr_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) clr_n = 1'b0;
            if (hold == 0) begin
                din  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            hold--;
        end

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule
